// File: rtl/io_bus_ctrl.sv
// ---------------------------------------------------------------------------
// io_bus_ctrl : memory-mapped I/O block for a small CPU bus.
//   HEX display register, LED register, debounced KEY/SW inputs with
//   ready/overrun/interrupt-enable status, and a prescaled interval timer.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   addr, wdata       : bus address and write data (DBITS)
//   wrmem, rdmem      : write strobe, read strobe (read clears input ready)
//   rdata, hit        : combinational read data and address-match flag
//   KEY (active-low), SW : raw board inputs
//   HEXOUT, LEDR      : display/LED registers
//   intr              : registered OR of (ready & IE) over KEY, SW, timer
// Supports HEXDIGITS up to 8.
// ---------------------------------------------------------------------------

// Two-flop synchroniser followed by a stability-count debouncer.
module io_bus_sync_db #(
    parameter int W        = 4,
    parameter int DEBOUNCE = 4,
    parameter bit INVERT   = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_i,
    output logic [W-1:0] acc_o,
    output logic         accept_o
);
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    logic [W-1:0]  sync1_q, sync2_q, acc_q, acc_d, in_s;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept_s;

    // Optional inversion so a pressed active-low key reads as 1.
    always_comb begin
        if (INVERT) begin
            in_s = ~in_i;
        end else begin
            in_s = in_i;
        end
    end

    // Count consecutive cycles the synchronised value differs from the
    // accepted one; any match restarts the count.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = {CW{1'b0}};
        accept_s = 1'b0;
        if (sync2_q != acc_q) begin
            if (cnt_q == CW'(DEBOUNCE - 1)) begin
                acc_d    = sync2_q;
                accept_s = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = {CW{1'b0}};
        end
    end

    // Synchroniser, accepted value and debounce counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= {W{1'b0}};
            sync2_q <= {W{1'b0}};
            acc_q   <= {W{1'b0}};
            cnt_q   <= {CW{1'b0}};
        end else begin
            sync1_q <= in_s;
            sync2_q <= sync1_q;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign acc_o    = acc_q;
    assign accept_o = accept_s;
endmodule

// Ready / overrun / interrupt-enable status bits of one device.
module io_bus_status #(
    parameter bit WR_CLR_RDY = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic set_i,
    input  logic rd_clr_i,
    input  logic wr_i,
    input  logic w0_i,
    input  logic w2_i,
    input  logic w4_i,
    output logic ready_o,
    output logic ovr_o,
    output logic ie_o
);
    logic ready_q, ready_d, ovr_q, ovr_d, ie_q, ie_d;

    // A new event always wins over a same-cycle clear.
    always_comb begin
        if (set_i) begin
            ready_d = 1'b1;
        end else if (rd_clr_i || (WR_CLR_RDY && wr_i && !w0_i)) begin
            ready_d = 1'b0;
        end else begin
            ready_d = ready_q;
        end
        if (set_i && ready_q) begin
            ovr_d = 1'b1;
        end else if (wr_i && !w2_i) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
        if (wr_i) begin
            ie_d = w4_i;
        end else begin
            ie_d = ie_q;
        end
    end

    // Status bit registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            ie_q    <= 1'b0;
        end else begin
            ready_q <= ready_d;
            ovr_q   <= ovr_d;
            ie_q    <= ie_d;
        end
    end

    assign ready_o = ready_q;
    assign ovr_o   = ovr_q;
    assign ie_o    = ie_q;
endmodule

module io_bus_ctrl #(
    parameter int DBITS     = 32,
    parameter int HEXDIGITS = 6,
    parameter int LEDBITS   = 10,
    parameter int KEYBITS   = 4,
    parameter int SWBITS    = 10,
    parameter int DEBOUNCE  = 4,
    parameter int PRESCALE  = 10,
    parameter logic [DBITS-1:0] ADDRHEX   = 32'hFFFF_F000,
    parameter logic [DBITS-1:0] ADDRLEDR  = 32'hFFFF_F020,
    parameter logic [DBITS-1:0] ADDRKEY   = 32'hFFFF_F080,
    parameter logic [DBITS-1:0] ADDRKCTRL = 32'hFFFF_F084,
    parameter logic [DBITS-1:0] ADDRSW    = 32'hFFFF_F090,
    parameter logic [DBITS-1:0] ADDRSCTRL = 32'hFFFF_F094,
    parameter logic [DBITS-1:0] ADDRTCNT  = 32'hFFFF_F100,
    parameter logic [DBITS-1:0] ADDRTLIM  = 32'hFFFF_F104,
    parameter logic [DBITS-1:0] ADDRTCTL  = 32'hFFFF_F108
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DBITS-1:0]       addr,
    input  logic                   wrmem,
    input  logic                   rdmem,
    input  logic [DBITS-1:0]       wdata,
    output logic [DBITS-1:0]       rdata,
    output logic                   hit,
    input  logic [KEYBITS-1:0]     KEY,
    input  logic [SWBITS-1:0]      SW,
    output logic [4*HEXDIGITS-1:0] HEXOUT,
    output logic [LEDBITS-1:0]     LEDR,
    output logic                   intr
);
    localparam int HB    = 4 * HEXDIGITS;
    localparam int PS_CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [31:0] HEX_RST = 32'h00FE_DEAD;

    // Status word layout: IE at bit4, overrun at bit2, ready at bit0.
    function automatic logic [DBITS-1:0] ctrl_word(input logic ie, input logic ovr, input logic rdy);
        ctrl_word    = {DBITS{1'b0}};
        ctrl_word[4] = ie;
        ctrl_word[2] = ovr;
        ctrl_word[0] = rdy;
    endfunction

    logic [HB-1:0]      hex_q, hex_d;
    logic [LEDBITS-1:0] led_q, led_d;
    logic [DBITS-1:0]   tcnt_q, tcnt_d, tlim_q, tlim_d;
    logic [PS_CW-1:0]   presc_q, presc_d;
    logic               intr_q, intr_d;
    logic               wrap_s;
    logic [KEYBITS-1:0] key_acc_s;
    logic [SWBITS-1:0]  sw_acc_s;
    logic               key_acc_ev_s, sw_acc_ev_s;
    logic               k_rdy_s, k_ovr_s, k_ie_s, s_rdy_s, s_ovr_s, s_ie_s, t_rdy_s, t_ovr_s, t_ie_s;

    wire wr_hex_s   = wrmem && (addr == ADDRHEX);
    wire wr_led_s   = wrmem && (addr == ADDRLEDR);
    wire wr_kctl_s  = wrmem && (addr == ADDRKCTRL);
    wire wr_sctl_s  = wrmem && (addr == ADDRSCTRL);
    wire wr_tcnt_s  = wrmem && (addr == ADDRTCNT);
    wire wr_tlim_s  = wrmem && (addr == ADDRTLIM);
    wire wr_tctl_s  = wrmem && (addr == ADDRTCTL);
    wire rd_key_s   = rdmem && (addr == ADDRKEY);
    wire rd_sw_s    = rdmem && (addr == ADDRSW);
    wire tlim_zero_s = (tlim_q == {DBITS{1'b0}});
    wire tick_s      = !tlim_zero_s && (presc_q == PS_CW'(PRESCALE - 1));

    io_bus_sync_db #(.W(KEYBITS), .DEBOUNCE(DEBOUNCE), .INVERT(1'b1)) u_key_db (
        .clk(clk), .reset(reset), .in_i(KEY), .acc_o(key_acc_s), .accept_o(key_acc_ev_s));
    io_bus_sync_db #(.W(SWBITS), .DEBOUNCE(DEBOUNCE), .INVERT(1'b0)) u_sw_db (
        .clk(clk), .reset(reset), .in_i(SW), .acc_o(sw_acc_s), .accept_o(sw_acc_ev_s));

    io_bus_status #(.WR_CLR_RDY(1'b0)) u_key_st (
        .clk(clk), .reset(reset), .set_i(key_acc_ev_s), .rd_clr_i(rd_key_s), .wr_i(wr_kctl_s),
        .w0_i(wdata[0]), .w2_i(wdata[2]), .w4_i(wdata[4]),
        .ready_o(k_rdy_s), .ovr_o(k_ovr_s), .ie_o(k_ie_s));
    io_bus_status #(.WR_CLR_RDY(1'b0)) u_sw_st (
        .clk(clk), .reset(reset), .set_i(sw_acc_ev_s), .rd_clr_i(rd_sw_s), .wr_i(wr_sctl_s),
        .w0_i(wdata[0]), .w2_i(wdata[2]), .w4_i(wdata[4]),
        .ready_o(s_rdy_s), .ovr_o(s_ovr_s), .ie_o(s_ie_s));
    io_bus_status #(.WR_CLR_RDY(1'b1)) u_tmr_st (
        .clk(clk), .reset(reset), .set_i(wrap_s), .rd_clr_i(1'b0), .wr_i(wr_tctl_s),
        .w0_i(wdata[0]), .w2_i(wdata[2]), .w4_i(wdata[4]),
        .ready_o(t_rdy_s), .ovr_o(t_ovr_s), .ie_o(t_ie_s));

    // Output registers, timer limit and interrupt next-state.
    always_comb begin
        hex_d  = wr_hex_s  ? wdata[HB-1:0]      : hex_q;
        led_d  = wr_led_s  ? wdata[LEDBITS-1:0] : led_q;
        tlim_d = wr_tlim_s ? wdata              : tlim_q;
        intr_d = (k_rdy_s & k_ie_s) | (s_rdy_s & s_ie_s) | (t_rdy_s & t_ie_s);
    end

    // Timer: a zero limit parks everything at 0; a count write beats a tick.
    // The >= compare also wraps a count left above a freshly shrunk limit.
    always_comb begin
        tcnt_d  = tcnt_q;
        presc_d = presc_q;
        wrap_s  = 1'b0;
        if (tlim_zero_s) begin
            tcnt_d  = {DBITS{1'b0}};
            presc_d = {PS_CW{1'b0}};
        end else if (wr_tcnt_s) begin
            tcnt_d  = wdata;
            presc_d = {PS_CW{1'b0}};
        end else if (tick_s) begin
            presc_d = {PS_CW{1'b0}};
            if (tcnt_q >= (tlim_q - DBITS'(1))) begin
                tcnt_d = {DBITS{1'b0}};
                wrap_s = 1'b1;
            end else begin
                tcnt_d = tcnt_q + DBITS'(1);
            end
        end else begin
            presc_d = presc_q + PS_CW'(1);
        end
    end

    // Register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_q   <= HEX_RST[HB-1:0];
            led_q   <= {LEDBITS{1'b0}};
            tcnt_q  <= {DBITS{1'b0}};
            tlim_q  <= {DBITS{1'b0}};
            presc_q <= {PS_CW{1'b0}};
            intr_q  <= 1'b0;
        end else begin
            hex_q   <= hex_d;
            led_q   <= led_d;
            tcnt_q  <= tcnt_d;
            tlim_q  <= tlim_d;
            presc_q <= presc_d;
            intr_q  <= intr_d;
        end
    end

    // Combinational read mux.
    always_comb begin
        rdata = {DBITS{1'b0}};
        hit   = 1'b1;
        case (addr)
            ADDRHEX:   rdata[HB-1:0]      = hex_q;
            ADDRLEDR:  rdata[LEDBITS-1:0] = led_q;
            ADDRKEY:   rdata[KEYBITS-1:0] = key_acc_s;
            ADDRKCTRL: rdata              = ctrl_word(k_ie_s, k_ovr_s, k_rdy_s);
            ADDRSW:    rdata[SWBITS-1:0]  = sw_acc_s;
            ADDRSCTRL: rdata              = ctrl_word(s_ie_s, s_ovr_s, s_rdy_s);
            ADDRTCNT:  rdata              = tcnt_q;
            ADDRTLIM:  rdata              = tlim_q;
            ADDRTCTL:  rdata              = ctrl_word(t_ie_s, t_ovr_s, t_rdy_s);
            default:   hit                = 1'b0;
        endcase
    end

    assign HEXOUT = hex_q;
    assign LEDR   = led_q;
    assign intr   = intr_q;
endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed testbench for io_bus_ctrl with default parameters.
module tb_io_bus_ctrl;
    localparam logic [31:0] A_HEX   = 32'hFFFF_F000;
    localparam logic [31:0] A_LEDR  = 32'hFFFF_F020;
    localparam logic [31:0] A_KEY   = 32'hFFFF_F080;
    localparam logic [31:0] A_KCTRL = 32'hFFFF_F084;
    localparam logic [31:0] A_SW    = 32'hFFFF_F090;
    localparam logic [31:0] A_SCTRL = 32'hFFFF_F094;
    localparam logic [31:0] A_TCNT  = 32'hFFFF_F100;
    localparam logic [31:0] A_TLIM  = 32'hFFFF_F104;
    localparam logic [31:0] A_TCTL  = 32'hFFFF_F108;

    logic        clk = 1'b0;
    logic        reset_s = 1'b1;
    logic [31:0] addr_s = 32'h0;
    logic        wrmem_s = 1'b0;
    logic        rdmem_s = 1'b0;
    logic [31:0] wdata_s = 32'h0;
    logic [31:0] rdata_s;
    logic        hit_s;
    logic [3:0]  key_s = 4'hF;
    logic [9:0]  sw_s = 10'h0;
    logic [23:0] hexout_s;
    logic [9:0]  ledr_s;
    logic        intr_s;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_bus_ctrl dut (
        .clk(clk), .reset(reset_s), .addr(addr_s), .wrmem(wrmem_s), .rdmem(rdmem_s),
        .wdata(wdata_s), .rdata(rdata_s), .hit(hit_s), .KEY(key_s), .SW(sw_s),
        .HEXOUT(hexout_s), .LEDR(ledr_s), .intr(intr_s));

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr_s = a; wdata_s = d; wrmem_s = 1'b1;
        @(posedge clk);
        #1;
        wrmem_s = 1'b0; wdata_s = 32'h0;
    endtask

    task automatic bus_read_clear(input logic [31:0] a);
        addr_s = a; rdmem_s = 1'b1;
        @(posedge clk);
        #1;
        rdmem_s = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a);
        addr_s = a;
        #1;
    endtask

    task automatic test_reset;
        reset_s = 1'b1;
        step(2);
        checks++; if (hexout_s !== 24'hFEDEAD) begin errors++; $display("FAIL rst_hex got %h want fedead", hexout_s); end
        checks++; if (ledr_s !== 10'h0) begin errors++; $display("FAIL rst_ledr got %h want 0", ledr_s); end
        checks++; if (intr_s !== 1'b0) begin errors++; $display("FAIL rst_intr got %b want 0", intr_s); end
        peek(A_HEX);
        checks++; if (rdata_s !== 32'h00FE_DEAD || hit_s !== 1'b1) begin errors++; $display("FAIL rst_rd_hex got %h/%b want 00fedead/1", rdata_s, hit_s); end
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'h0) begin errors++; $display("FAIL rst_tcnt got %h want 0", rdata_s); end
        reset_s = 1'b0;
        step(1);
    endtask

    task automatic test_hex_ledr;
        bus_write(A_HEX, 32'h0012_3456);
        checks++; if (hexout_s !== 24'h123456) begin errors++; $display("FAIL hex_out got %h want 123456", hexout_s); end
        peek(A_HEX);
        checks++; if (rdata_s !== 32'h0012_3456) begin errors++; $display("FAIL hex_rd got %h want 00123456", rdata_s); end
        bus_write(A_LEDR, 32'hFFFF_F2A5);
        checks++; if (ledr_s !== 10'h2A5) begin errors++; $display("FAIL ledr_out got %h want 2a5", ledr_s); end
        peek(A_LEDR);
        checks++; if (rdata_s !== 32'h0000_02A5) begin errors++; $display("FAIL ledr_rd got %h want 000002a5", rdata_s); end
        peek(32'hFFFF_F004);
        checks++; if (rdata_s !== 32'h0 || hit_s !== 1'b0) begin errors++; $display("FAIL unmapped got %h/%b want 0/0", rdata_s, hit_s); end
    endtask

    task automatic test_key;
        key_s = 4'b1110;
        step(5);
        peek(A_KEY);
        checks++; if (rdata_s !== 32'h0) begin errors++; $display("FAIL key_early got %h want 0", rdata_s); end
        step(1);
        peek(A_KEY);
        checks++; if (rdata_s !== 32'h1) begin errors++; $display("FAIL key_acc got %h want 1", rdata_s); end
        peek(A_KCTRL);
        checks++; if (rdata_s !== 32'h1) begin errors++; $display("FAIL kctrl_rdy got %h want 1", rdata_s); end
        key_s = 4'b1100;
        step(3);
        key_s = 4'b1110;
        step(8);
        peek(A_KEY);
        checks++; if (rdata_s !== 32'h1) begin errors++; $display("FAIL key_glitch got %h want 1", rdata_s); end
        peek(A_KCTRL);
        checks++; if (rdata_s !== 32'h1) begin errors++; $display("FAIL kctrl_glitch got %h want 1", rdata_s); end
        bus_read_clear(A_KEY);
        peek(A_KCTRL);
        checks++; if (rdata_s !== 32'h0) begin errors++; $display("FAIL kctrl_rdclr got %h want 0", rdata_s); end
    endtask

    task automatic test_sw;
        sw_s = 10'h005;
        step(6);
        peek(A_SCTRL);
        checks++; if (rdata_s !== 32'h1) begin errors++; $display("FAIL sctrl_first got %h want 1", rdata_s); end
        sw_s = 10'h00A;
        step(6);
        peek(A_SW);
        checks++; if (rdata_s !== 32'h00A) begin errors++; $display("FAIL sw_acc got %h want 00a", rdata_s); end
        peek(A_SCTRL);
        checks++; if (rdata_s !== 32'h5) begin errors++; $display("FAIL sctrl_ovr got %h want 5", rdata_s); end
        bus_read_clear(A_SW);
        peek(A_SCTRL);
        checks++; if (rdata_s !== 32'h4) begin errors++; $display("FAIL sctrl_rdclr got %h want 4", rdata_s); end
        bus_write(A_SCTRL, 32'h0000_0005);
        peek(A_SCTRL);
        checks++; if (rdata_s !== 32'h4) begin errors++; $display("FAIL sctrl_wr_noset got %h want 4", rdata_s); end
        bus_write(A_SCTRL, 32'h0);
        peek(A_SCTRL);
        checks++; if (rdata_s !== 32'h0) begin errors++; $display("FAIL sctrl_clr got %h want 0", rdata_s); end
    endtask

    task automatic test_timer;
        bus_write(A_TCTL, 32'h10);
        bus_write(A_TLIM, 32'd3);
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd0) begin errors++; $display("FAIL tcnt_t0 got %0d want 0", rdata_s); end
        step(9);
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd0) begin errors++; $display("FAIL tcnt_t9 got %0d want 0", rdata_s); end
        step(1);
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd1) begin errors++; $display("FAIL tcnt_t10 got %0d want 1", rdata_s); end
        step(10);
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd2) begin errors++; $display("FAIL tcnt_t20 got %0d want 2", rdata_s); end
        step(10);
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd0) begin errors++; $display("FAIL tcnt_wrap got %0d want 0", rdata_s); end
        peek(A_TCTL);
        checks++; if (rdata_s !== 32'h11) begin errors++; $display("FAIL tctl_rdy got %h want 11", rdata_s); end
        checks++; if (intr_s !== 1'b0) begin errors++; $display("FAIL intr_early got %b want 0", intr_s); end
        step(1);
        checks++; if (intr_s !== 1'b1) begin errors++; $display("FAIL intr_set got %b want 1", intr_s); end
        step(29);
        peek(A_TCTL);
        checks++; if (rdata_s !== 32'h15) begin errors++; $display("FAIL tctl_ovr got %h want 15", rdata_s); end
        bus_write(A_TCTL, 32'h10);
        peek(A_TCTL);
        checks++; if (rdata_s !== 32'h10) begin errors++; $display("FAIL tctl_clr got %h want 10", rdata_s); end
        step(1);
        checks++; if (intr_s !== 1'b0) begin errors++; $display("FAIL intr_clr got %b want 0", intr_s); end
        // count above limit wraps on the next tick
        bus_write(A_TCNT, 32'd5);
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd5) begin errors++; $display("FAIL tcnt_load got %0d want 5", rdata_s); end
        step(9);
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd5) begin errors++; $display("FAIL tcnt_hold got %0d want 5", rdata_s); end
        step(1);
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd0) begin errors++; $display("FAIL tcnt_over_wrap got %0d want 0", rdata_s); end
        peek(A_TCTL);
        checks++; if (rdata_s !== 32'h11) begin errors++; $display("FAIL tctl_over_rdy got %h want 11", rdata_s); end
    endtask

    task automatic test_back_to_back;
        // write lands on the same edge as a tick
        step(9);
        bus_write(A_TCNT, 32'd2);
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd2) begin errors++; $display("FAIL tcnt_wr_wins got %0d want 2", rdata_s); end
        step(9);
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd2) begin errors++; $display("FAIL tcnt_after_wr got %0d want 2", rdata_s); end
        step(1);
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd0) begin errors++; $display("FAIL tcnt_wr_wrap got %0d want 0", rdata_s); end
        step(10);
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd1) begin errors++; $display("FAIL tcnt_pre_zero got %0d want 1", rdata_s); end
        bus_write(A_TLIM, 32'd0);
        step(1);
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd0) begin errors++; $display("FAIL tcnt_tlim0 got %0d want 0", rdata_s); end
        step(20);
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd0) begin errors++; $display("FAIL tcnt_tlim0_hold got %0d want 0", rdata_s); end
    endtask

    task automatic test_reset_mid;
        bus_write(A_HEX, 32'h00AB_CDEF);
        bus_write(A_TLIM, 32'd3);
        step(15);
        key_s = 4'b0000;
        step(2);
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd1) begin errors++; $display("FAIL pre_rst_tcnt got %0d want 1", rdata_s); end
        checks++; if (intr_s !== 1'b1) begin errors++; $display("FAIL pre_rst_intr got %b want 1", intr_s); end
        reset_s = 1'b1;
        #1;
        checks++; if (hexout_s !== 24'hFEDEAD) begin errors++; $display("FAIL mid_rst_hex got %h want fedead", hexout_s); end
        checks++; if (ledr_s !== 10'h0) begin errors++; $display("FAIL mid_rst_ledr got %h want 0", ledr_s); end
        checks++; if (intr_s !== 1'b0) begin errors++; $display("FAIL mid_rst_intr got %b want 0", intr_s); end
        checks++; if (rdata_s !== 32'd0) begin errors++; $display("FAIL mid_rst_tcnt got %0d want 0", rdata_s); end
        peek(A_TLIM);
        checks++; if (rdata_s !== 32'd0) begin errors++; $display("FAIL mid_rst_tlim got %0d want 0", rdata_s); end
        peek(A_TCTL);
        checks++; if (rdata_s !== 32'h0) begin errors++; $display("FAIL mid_rst_tctl got %h want 0", rdata_s); end
        key_s = 4'hF;
        step(2);
        reset_s = 1'b0;
        step(10);
        peek(A_KEY);
        checks++; if (rdata_s !== 32'h0) begin errors++; $display("FAIL post_rst_key got %h want 0", rdata_s); end
        peek(A_TCNT);
        checks++; if (rdata_s !== 32'd0) begin errors++; $display("FAIL post_rst_tcnt got %0d want 0", rdata_s); end
        checks++; if (hexout_s !== 24'hFEDEAD) begin errors++; $display("FAIL post_rst_hex got %h want fedead", hexout_s); end
    endtask

    initial begin
        test_reset();
        test_hex_ledr();
        test_key();
        test_sw();
        test_timer();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
